// File: rtl/encoder_pkg.sv
// Shared types and constants for the multi-hot stream encoder.
package encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_t;

  localparam logic MODE_ASC  = 1'b0;
  localparam logic MODE_DESC = 1'b1;

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: lowest or highest set bit of vec,
// plus flags for "any bit set" and "exactly one bit set".
module prio_enc #(
  parameter  int N = 64,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic         msb_first,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  // The last match in the loop wins, so the scan direction picks the priority.
  always_comb begin
    idx = '0;
    if (msb_first) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/multihot_stream_encoder.sv
// Streams the index of every set bit of an accepted request vector as
// valid/ready beats, lowest-first or highest-first.
module multihot_stream_encoder
  import encoder_pkg::*;
#(
  parameter  int N = 64,
  localparam int W = $clog2(N)
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [W:0]   out_beat,
  output logic         out_last,
  output logic         out_empty
);

  enc_state_t   state;
  logic [N-1:0] pending;
  logic         mode_q;
  logic [W:0]   beat_q;
  logic         empty_q;

  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         enc_single;
  logic         draining;
  logic         fire;
  logic         accept;
  logic [N-1:0] clear_mask;

  prio_enc #(.N(N)) u_prio_enc (
    .vec       (pending),
    .msb_first (mode_q == MODE_DESC),
    .idx       (enc_idx),
    .any       (enc_any),
    .single    (enc_single)
  );

  assign draining  = (state == DRAIN);
  assign out_valid = draining;
  assign out_idx   = (draining && !empty_q) ? enc_idx : '0;
  assign out_beat  = draining ? beat_q : '0;
  assign out_last  = draining && (empty_q || enc_single);
  assign out_empty = draining && empty_q;

  assign fire     = out_valid && out_ready;
  // Accepting on the final handshake lets consecutive vectors run without a bubble.
  assign in_ready = !draining || (fire && out_last);
  assign accept   = in_valid && in_ready;

  assign clear_mask = {{(N-1){1'b0}}, 1'b1} << enc_idx;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      pending <= '0;
      mode_q  <= MODE_ASC;
      beat_q  <= '0;
      empty_q <= 1'b0;
    end else if (accept) begin
      state   <= DRAIN;
      pending <= in_data;
      mode_q  <= in_mode;
      beat_q  <= '0;
      empty_q <= (in_data == '0);
    end else if (fire) begin
      if (enc_any) pending <= pending & ~clear_mask;
      beat_q <= beat_q + 1'b1;
      if (out_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_multihot_stream_encoder.sv
// Randomised and directed checks of multihot_stream_encoder against a
// list-of-set-bits reference model.
module tb_multihot_stream_encoder;

  localparam int N = 64;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_idx;
  logic [W:0]   out_beat;
  logic         out_last;
  logic         out_empty;

  int checks = 0;
  int failures = 0;
  bit timed_out;

  typedef struct {
    int idx;
    int beat;
    bit last;
    bit empty;
    int cyc;
  } beat_t;

  beat_t got[$];
  int    exp_idx[$];
  bit    exp_empty;

  always #5 clk = ~clk;

  multihot_stream_encoder #(.N(N)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_beat  (out_beat),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  // Reference: the list of set-bit positions in scan order; an empty vector
  // yields a single beat at index 0.
  task automatic model(input logic [N-1:0] v, input bit desc);
    exp_idx.delete();
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (desc) exp_idx.push_front(i);
        else exp_idx.push_back(i);
      end
    end
    exp_empty = (exp_idx.size() == 0);
    if (exp_empty) exp_idx.push_back(0);
  endtask

  task automatic send(input logic [N-1:0] d, input bit m);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  // Records every handshaked beat until the last one; in_mode is toggled at
  // random to show it is ignored mid-vector.
  task automatic collect(input int stall_pct, input int max_cyc);
    bit done;
    beat_t b;
    done = 1'b0;
    timed_out = 1'b0;
    got.delete();
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      in_mode   = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        b.idx = int'(out_idx);
        b.beat = int'(out_beat);
        b.last = out_last;
        b.empty = out_empty;
        b.cyc = c;
        got.push_back(b);
        if (out_last) done = 1'b1;
      end
    end
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_idx, out_beat, out_last, out_empty} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b idx=%0d beat=%0d last=%0b empty=%0b want all 0",
               out_valid, out_idx, out_beat, out_last, out_empty);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan_order;
    for (int m = 0; m < 2; m++) begin
      send(64'h29, 1'(m));
      collect(0, 100);
      model(64'h29, 1'(m));
      checks++;
      if (timed_out || got.size() != exp_idx.size()) begin
        failures++;
        $display("FAIL scan_count mode=%0d got %0d beats want %0d", m, got.size(), exp_idx.size());
      end else begin
        for (int k = 0; k < got.size(); k++) begin
          checks++;
          if (got[k].idx != exp_idx[k] || got[k].beat != k || got[k].cyc != k ||
              got[k].last != (k == got.size() - 1) || got[k].empty != 1'b0) begin
            failures++;
            $display("FAIL scan_beat mode=%0d k=%0d got idx=%0d beat=%0d cyc=%0d last=%0b empty=%0b want idx=%0d beat=%0d cyc=%0d last=%0b empty=0",
                     m, k, got[k].idx, got[k].beat, got[k].cyc, got[k].last, got[k].empty,
                     exp_idx[k], k, k, (k == got.size() - 1));
          end
        end
      end
      $display("test_scan_order mode=%0d beats=%0d", m, got.size());
    end
  endtask

  task automatic test_backpressure;
    send(64'h8000_0000_0000_0001, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_beat !== 7'd0 || out_last !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold s=%0d got valid=%0b idx=%0d beat=%0d last=%0b want 1/0/0/0",
                 s, out_valid, out_idx, out_beat, out_last);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_beat !== 7'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got valid=%0b idx=%0d beat=%0d last=%0b want 1/0/0/0",
               out_valid, out_idx, out_beat, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 6'd63 || out_beat !== 7'd1 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL stall_second got valid=%0b idx=%0d beat=%0d last=%0b want 1/63/1/1",
               out_valid, out_idx, out_beat, out_last);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_empty_full;
    send('0, 1'b0);
    collect(0, 20);
    checks++;
    if (timed_out || got.size() != 1 || got[0].idx != 0 || got[0].empty != 1'b1 ||
        got[0].last != 1'b1 || got[0].beat != 0) begin
      failures++;
      $display("FAIL empty_vec got beats=%0d timeout=%0b want one beat idx=0 empty=1 last=1",
               got.size(), timed_out);
    end
    $display("test_empty beats=%0d", got.size());
    send('1, 1'b0);
    collect(0, 200);
    checks++;
    if (timed_out || got.size() != N) begin
      failures++;
      $display("FAIL full_count got %0d beats want %0d", got.size(), N);
    end else begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (got[k].idx != k || got[k].beat != k || got[k].cyc != k ||
            got[k].last != (k == N - 1) || got[k].empty != 1'b0) begin
          failures++;
          $display("FAIL full_beat k=%0d got idx=%0d beat=%0d cyc=%0d last=%0b want idx=%0d beat=%0d last=%0b",
                   k, got[k].idx, got[k].beat, got[k].cyc, got[k].last, k, k, (k == N - 1));
        end
      end
    end
    $display("test_full beats=%0d", got.size());
  endtask

  task automatic test_back_to_back;
    int want_idx[3] = '{0, 1, 2};
    int want_beat[3] = '{0, 1, 0};
    bit want_last[3] = '{1'b0, 1'b1, 1'b1};
    beat_t b;
    got.delete();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 64'h3;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_data = 64'h4;
    for (int c = 0; c < 6 && got.size() < 3; c++) begin
      @(negedge clk);
      #1;
      if (c < 2) begin
        checks++;
        if (in_ready !== (c == 1)) begin
          failures++;
          $display("FAIL b2b_in_ready c=%0d got %0b want %0b", c, in_ready, (c == 1));
        end
      end
      if (out_valid && out_ready) begin
        b.idx = int'(out_idx);
        b.beat = int'(out_beat);
        b.last = out_last;
        b.empty = out_empty;
        b.cyc = c;
        got.push_back(b);
      end
      if (c == 1) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got %0d beats want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k].idx != want_idx[k] || got[k].beat != want_beat[k] ||
            got[k].last != want_last[k] || got[k].cyc != k) begin
          failures++;
          $display("FAIL b2b_beat k=%0d got idx=%0d beat=%0d last=%0b cyc=%0d want idx=%0d beat=%0d last=%0b cyc=%0d",
                   k, got[k].idx, got[k].beat, got[k].last, got[k].cyc,
                   want_idx[k], want_beat[k], want_last[k], k);
        end
      end
    end
    $display("test_back_to_back beats=%0d", got.size());
  endtask

  task automatic test_reset_mid;
    send(64'hFF, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_beat !== 7'd2 || out_idx !== 6'd2) begin
      failures++;
      $display("FAIL mid_pre_reset got valid=%0b beat=%0d idx=%0d want 1/2/2", out_valid, out_beat, out_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_after_reset got valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    send(64'h10, 1'b0);
    collect(0, 20);
    checks++;
    if (timed_out || got.size() != 1 || got[0].idx != 4 || got[0].beat != 0 ||
        got[0].last != 1'b1 || got[0].cyc != 0) begin
      failures++;
      $display("FAIL mid_new_vector got beats=%0d timeout=%0b want one beat idx=4 beat=0 last=1",
               got.size(), timed_out);
    end
    $display("test_reset_mid beats=%0d", got.size());
  endtask

  task automatic test_random;
    logic [N-1:0] v;
    bit m;
    int kind;
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       v = '0;
        1:       v = '1;
        2:       v = {{(N-1){1'b0}}, 1'b1} << $urandom_range(0, N - 1);
        default: v = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      m = 1'($urandom_range(0, 1));
      send(v, m);
      collect(30, 1000);
      model(v, m);
      checks++;
      if (timed_out || got.size() != exp_idx.size()) begin
        failures++;
        $display("FAIL rand_count t=%0d vec=%h got %0d beats want %0d", t, v, got.size(), exp_idx.size());
      end else begin
        for (int k = 0; k < got.size(); k++) begin
          checks++;
          if (got[k].idx != exp_idx[k] || got[k].beat != k || got[k].empty != exp_empty ||
              got[k].last != (k == got.size() - 1)) begin
            failures++;
            $display("FAIL rand_beat t=%0d k=%0d got idx=%0d beat=%0d last=%0b empty=%0b want idx=%0d beat=%0d last=%0b empty=%0b",
                     t, k, got[k].idx, got[k].beat, got[k].last, got[k].empty,
                     exp_idx[k], k, (k == got.size() - 1), exp_empty);
          end
        end
      end
      $display("test_random t=%0d vec=%h mode=%0d beats=%0d", t, v, m, got.size());
    end
  endtask

  initial begin
    test_reset;
    test_scan_order;
    test_backpressure;
    test_empty_full;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
